// File: rtl/cpu16_pkg.sv
// cpu16_pkg: shared constants and the operand-bundle type for the operand
// fetch stage.
//   DATA_WIDTH  - operand width in bits
//   NUM_REGS    - number of architectural registers
//   INDEX_WIDTH - register index width
//   OP_WIDTH    - opaque opcode width carried through the stage
//   operand_bundle_t - registered payload handed to the downstream stage
package cpu16_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int NUM_REGS    = 8;
    localparam int INDEX_WIDTH = $clog2(NUM_REGS);
    localparam int OP_WIDTH    = 4;

    typedef struct packed {
        logic [OP_WIDTH-1:0]    op;
        logic [INDEX_WIDTH-1:0] rd;
        logic                   writes_rd;
        logic [DATA_WIDTH-1:0]  a;
        logic [DATA_WIDTH-1:0]  b;
    } operand_bundle_t;

endpackage

// File: rtl/scoreboard.sv
// scoreboard: one pending bit per architectural register, marking a write
// that has been issued but not yet written back. Also performs the hazard
// lookup for the instruction currently offered to the fetch stage.
//   i_clk, i_rst       - clock, synchronous active-high reset
//   i_chk_valid        - an instruction is being offered (enables hazard)
//   i_chk_rs1/rs2/rd   - indices of that instruction
//   i_chk_writes_rd    - that instruction writes i_chk_rd
//   i_set_en/addr      - mark a register pending (instruction accepted)
//   i_clr_en/addr      - writeback completing this cycle
//   o_hazard           - the offered instruction must stall
module scoreboard
    import cpu16_pkg::*;
#(
    parameter int NumRegs    = NUM_REGS,
    parameter int IndexWidth = $clog2(NumRegs)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_chk_valid,
    input  logic [IndexWidth-1:0] i_chk_rs1,
    input  logic [IndexWidth-1:0] i_chk_rs2,
    input  logic [IndexWidth-1:0] i_chk_rd,
    input  logic                  i_chk_writes_rd,
    input  logic                  i_set_en,
    input  logic [IndexWidth-1:0] i_set_addr,
    input  logic                  i_clr_en,
    input  logic [IndexWidth-1:0] i_clr_addr,
    output logic                  o_hazard
);

    logic [NumRegs-1:0] r_pending;
    logic [NumRegs-1:0] w_pending_nxt;
    logic               w_src1_busy;
    logic               w_src2_busy;
    logic               w_dst_busy;

    // A source whose writeback lands this very cycle is satisfied by the
    // forwarding path, so it does not stall. The destination gets no such
    // exemption: the older write has not retired until the edge.
    assign w_src1_busy = r_pending[i_chk_rs1] && !(i_clr_en && (i_clr_addr == i_chk_rs1));
    assign w_src2_busy = r_pending[i_chk_rs2] && !(i_clr_en && (i_clr_addr == i_chk_rs2));
    assign w_dst_busy  = i_chk_writes_rd && r_pending[i_chk_rd];
    assign o_hazard    = i_chk_valid && (w_src1_busy || w_src2_busy || w_dst_busy);

    // Clear is applied first so a same-cycle set of the same index wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (i_clr_en) begin
            w_pending_nxt[i_clr_addr] = 1'b0;
        end
        if (i_set_en) begin
            w_pending_nxt[i_set_addr] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: reads source operands for a decoded instruction, forwards
// same-cycle writeback data, stalls on pending-register hazards and presents
// a registered operand bundle with a valid/ready handshake.
//   clk, rst                      - clock, synchronous active-high reset
//   in_valid/in_ready             - upstream handshake
//   in_op, in_rs1, in_rs2, in_rd  - decoded instruction fields
//   in_writesRd                   - instruction writes in_rd
//   rf_readAddr1/2, rf_readData1/2 - asynchronous register-file read ports
//   wb_valid, wb_addr, wb_data    - writeback this cycle (also the RF write)
//   out_valid/out_ready           - downstream handshake
//   out_op, out_rd, out_writesRd, out_a, out_b - registered operand bundle
module operand_fetch
    import cpu16_pkg::*;
#(
    parameter int DataWidth  = DATA_WIDTH,
    parameter int NumRegs    = NUM_REGS,
    parameter int IndexWidth = $clog2(NumRegs),
    parameter int OpWidth    = OP_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OpWidth-1:0]    in_op,
    input  logic [IndexWidth-1:0] in_rs1,
    input  logic [IndexWidth-1:0] in_rs2,
    input  logic [IndexWidth-1:0] in_rd,
    input  logic                  in_writesRd,
    output logic [IndexWidth-1:0] rf_readAddr1,
    output logic [IndexWidth-1:0] rf_readAddr2,
    input  logic [DataWidth-1:0]  rf_readData1,
    input  logic [DataWidth-1:0]  rf_readData2,
    input  logic                  wb_valid,
    input  logic [IndexWidth-1:0] wb_addr,
    input  logic [DataWidth-1:0]  wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OpWidth-1:0]    out_op,
    output logic [IndexWidth-1:0] out_rd,
    output logic                  out_writesRd,
    output logic [DataWidth-1:0]  out_a,
    output logic [DataWidth-1:0]  out_b
);

    function automatic logic [DataWidth-1:0] forward_operand(
        input logic [IndexWidth-1:0] src,
        input logic [DataWidth-1:0]  rf_data,
        input logic                  wb_v,
        input logic [IndexWidth-1:0] wb_a,
        input logic [DataWidth-1:0]  wb_d
    );
        return (wb_v && (wb_a == src)) ? wb_d : rf_data;
    endfunction

    logic                 w_hazard;
    logic                 w_accept;
    logic [DataWidth-1:0] w_fwd_a_p0;
    logic [DataWidth-1:0] w_fwd_b_p0;

    operand_bundle_t      r_bundle_p1;
    logic                 r_vld_p1;

    assign rf_readAddr1 = in_rs1;
    assign rf_readAddr2 = in_rs2;

    assign w_fwd_a_p0 = forward_operand(in_rs1, rf_readData1, wb_valid, wb_addr, wb_data);
    assign w_fwd_b_p0 = forward_operand(in_rs2, rf_readData2, wb_valid, wb_addr, wb_data);

    assign in_ready = !rst && (!r_vld_p1 || out_ready) && !w_hazard;
    assign w_accept = in_valid && in_ready;

    scoreboard #(
        .NumRegs    (NumRegs),
        .IndexWidth (IndexWidth)
    ) u_scoreboard (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_chk_valid     (in_valid),
        .i_chk_rs1       (in_rs1),
        .i_chk_rs2       (in_rs2),
        .i_chk_rd        (in_rd),
        .i_chk_writes_rd (in_writesRd),
        .i_set_en        (w_accept && in_writesRd),
        .i_set_addr      (in_rd),
        .i_clr_en        (wb_valid),
        .i_clr_addr      (wb_addr),
        .o_hazard        (w_hazard)
    );

    // p0 -> p1: capture the operand bundle on accept; otherwise hold it
    // (stable under back-pressure) and drop valid once it is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1    <= 1'b0;
            r_bundle_p1 <= '0;
        end else if (w_accept) begin
            r_vld_p1              <= 1'b1;
            r_bundle_p1.op        <= in_op;
            r_bundle_p1.rd        <= in_rd;
            r_bundle_p1.writes_rd <= in_writesRd;
            r_bundle_p1.a         <= w_fwd_a_p0;
            r_bundle_p1.b         <= w_fwd_b_p0;
        end else if (r_vld_p1 && out_ready) begin
            r_vld_p1 <= 1'b0;
        end
    end

    assign out_valid    = r_vld_p1;
    assign out_op       = r_bundle_p1.op;
    assign out_rd       = r_bundle_p1.rd;
    assign out_writesRd = r_bundle_p1.writes_rd;
    assign out_a        = r_bundle_p1.a;
    assign out_b        = r_bundle_p1.b;

endmodule
